vec_mem_controller: RTL and testbench
=====================================

Name: vec_mem_controller

Overview:
Parametrised successor of the dual-vector operand store for the dotProduct datapath. It holds NUM_CH operand vectors, each in its own synchronous-read bank. Vectors are loaded in lockstep through a valid/ready write port and read back two ways:
- random access through a 1-cycle-latency read port, or
- as a streamed burst with valid/ready backpressure and a last flag, feeding the MAC stage directly.

Vector length is set at run time, up to DEPTH.

Parameters:
- DATA_WIDTH, 8, bits per element per channel.
- NUM_CH, 2, number of lockstep operand channels/banks.
- DEPTH, 32, max elements per vector (power of two not required).
- ADDR_WIDTH, clog2(DEPTH), element address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- cfg_len  in  ADDR_WIDTH+1  vector length, sampled when start is accepted.
- start  in  1  begin a load burst.
- in_valid  in  1  write element valid.
- in_ready  out  1  controller accepts an element.
- in_data  in  NUM_CH*DATA_WIDTH  one element per channel; ch0 in the LSBs.
- busy  out  1  high in LOAD or STREAM.
- done  out  1  one-cycle pulse when the last element is written.
- rd_en  in  1  random read request.
- rd_addr  in  ADDR_WIDTH  random read address, common to all channels.
- rd_valid  out  1  rd_data valid.
- rd_data  out  NUM_CH*DATA_WIDTH  random read result.
- strm_start  in  1  begin a stream burst.
- strm_valid  out  1  stream element valid.
- strm_ready  in  1  downstream accepts.
- strm_data  out  NUM_CH*DATA_WIDTH  stream element.
- strm_last  out  1  final element of the burst; qualified by strm_valid.
- err  out  1  one-cycle protocol or integrity error pulse.

Behaviour:
- Reset: state IDLE, wr_ptr=0, len=0. in_ready, busy, done, rd_valid, strm_valid, strm_last and err are all 0. rd_data and strm_data are 0. Bank contents are not cleared.
- Reset mid-LOAD or mid-STREAM aborts immediately to IDLE. A partial stream is discarded with no strm_last.
- State IDLE:
  - start with cfg_len=0: err pulse, stay IDLE.
  - start otherwise: latch len=min(cfg_len,DEPTH), wr_ptr=0, go to LOAD.
- State LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready writes in_data slice k to bank k at wr_ptr, then wr_ptr++.
  - The write at wr_ptr==len-1 pulses done in the following cycle and moves to LOADED.
  - start is ignored.
  - strm_start gives an err pulse.
- State LOADED:
  - start begins a new LOAD, overwriting from address 0.
  - strm_start begins STREAM with rd_ptr=0.
- State STREAM:
  - Reads are issued ahead into a 2-entry output skid buffer, so there is no bubble under continuous strm_ready.
  - First strm_valid appears 2 cycles after strm_start is sampled.
  - With strm_ready held high, one element per cycle; a burst of len elements completes len+1 cycles after start.
  - When strm_valid&!strm_ready, strm_data and strm_last hold stable.
  - Acceptance of the element with strm_last returns to LOADED.
  - start and strm_start are ignored.
- Random read:
  - rd_en is honoured in IDLE, LOAD and LOADED. rd_valid and rd_data follow on the next cycle.
  - rd_addr>=DEPTH returns 0 with an err pulse.
  - In STREAM, rd_en is ignored and rd_valid=0.
  - Same-cycle read and write to the same address returns old data (read-first).
- A stream can be replayed any number of times from LOADED without reloading.

Optional Feature:
- Macro: VEC_MEM_PARITY_EN.
- Defined:
  - each bank word stores an extra even-parity bit computed on write;
  - the bit is checked on every random read and stream read;
  - a mismatch pulses err in the same cycle the data becomes valid, and the data is still delivered.
- Undefined: no parity storage or check; err comes only from protocol errors.

Decomposition:
- Package vec_mem_pkg:
  - clog2 function;
  - state encoding IDLE/LOAD/LOADED/STREAM;
  - channel slice helper constant for DATA_WIDTH indexing.
- Sub-module vec_mem_bank: one 1W1R synchronous RAM of DEPTH x (DATA_WIDTH [+1 parity]), read-first. It is instantiated NUM_CH times via generate.
- The FSM, pointers and skid buffer stay in the top level.

Test Plan:
1. Reset, then start with cfg_len=3 and writes (10,200), (20,150), (30,100) with one idle gap. Expected:
   - done pulses exactly once, one cycle after the third write;
   - random reads of addr 0/1/2 return A=10/20/30, B=200/150/100 one cycle after rd_en.
2. Load 32 elements (A=i, B=~i), then strm_start with strm_ready=1. Expected:
   - 32 consecutive strm_valid beats, in order;
   - strm_last only on beat 31;
   - return to LOADED; busy low afterwards.
3. Stream of length 4 with strm_ready toggled 1,0,0,1,... Expected:
   - no element is lost or duplicated;
   - data and last are held stable while stalled.
4. Protocol errors:
   - start with cfg_len=0 → err pulse, stay IDLE;
   - strm_start during LOAD → err pulse;
   - cfg_len=40 → clamps to 32, and done fires after 32 writes.
5. Assert rst for one cycle after 2 of 4 stream beats. Expected:
   - outputs return to their reset values on the next edge;
   - after re-entering LOADED via start/load, a replayed stream returns the new data.
6. With VEC_MEM_PARITY_EN, force-flip one stored bit at addr 5, then random-read addr 5. Expected:
   - err pulse with rd_valid;
   - reads of other addresses give no err.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared types and helpers for the vector operand store.
// Optional parity protection is enabled by defining VEC_MEM_PARITY_EN.
package vec_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOADED,
    STREAM
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Low bit of channel ch inside a packed multi-channel word.
  function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/vec_mem_bank.sv
// One 1W1R synchronous RAM bank, read-first on same-address collision.
// Word width includes the parity bit when VEC_MEM_PARITY_EN is defined.
module vec_mem_bank
  import vec_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vec_mem_controller.sv
// Multi-channel operand vector store: lockstep load, random read, streamed burst.
// Define VEC_MEM_PARITY_EN to store and check an even-parity bit per bank word.
module vec_mem_controller
  import vec_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH:0]          cfg_len,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         busy,
  output logic                         done,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  input  logic                         strm_start,
  output logic                         strm_valid,
  input  logic                         strm_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] strm_data,
  output logic                         strm_last,
  output logic                         err
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam int unsigned VW = NUM_CH * DATA_WIDTH;
`ifdef VEC_MEM_PARITY_EN
  localparam int unsigned BW = DATA_WIDTH + 1;
`else
  localparam int unsigned BW = DATA_WIDTH;
`endif
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t                state, state_nxt;
  logic [LW-1:0]         len, rd_ptr, issue_idx;
  logic [ADDR_WIDTH-1:0] wr_ptr, bank_raddr;
  logic                  load_go, strm_go, proto_err, wr_fire, wr_last, rd_fire, stream_on;
  logic                  done_q, err_q, rd_valid_q, rd_oob_q, rd_oob;
  logic                  pop, strm_issue, bank_re, inflight, inflight_last;
  logic [1:0]            occ, count, count_nxt;
  logic [1:0][VW-1:0]    sk_data, sk_data_nxt;
  logic [1:0]            sk_last, sk_last_nxt, sk_perr, sk_perr_nxt;
  logic [VW-1:0]         bank_flat;
  logic [NUM_CH-1:0]     bank_perr_ch;
  logic                  bank_perr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_go   = 1'b0;
    strm_go   = 1'b0;
    proto_err = 1'b0;
    wr_fire   = 1'b0;
    wr_last   = 1'b0;
    rd_fire   = 1'b0;
    stream_on = 1'b0;
    case (state)
      IDLE, LOADED: begin
        if (start) begin
          if (cfg_len == '0) proto_err = 1'b1;
          else begin
            load_go   = 1'b1;
            state_nxt = LOAD;
          end
        end else if (state == LOADED && strm_start) begin
          strm_go   = 1'b1;
          state_nxt = STREAM;
        end
        rd_fire = rd_en && !strm_go;
      end
      LOAD: begin
        rd_fire   = rd_en;
        wr_fire   = in_valid;
        proto_err = strm_start;
        if (in_valid && ({1'b0, wr_ptr} == len - LW'(1))) begin
          wr_last   = 1'b1;
          state_nxt = LOADED;
        end
      end
      STREAM: begin
        stream_on = 1'b1;
        if (pop && sk_last[0]) state_nxt = LOADED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reads run one element ahead of the skid buffer; occupancy counts the read in flight.
  assign pop        = strm_valid & strm_ready;
  assign occ        = count + {1'b0, inflight} - {1'b0, pop};
  assign issue_idx  = strm_go ? '0 : rd_ptr;
  assign strm_issue = strm_go | (stream_on & (rd_ptr < len) & (occ < 2'd2));
  assign rd_oob     = ({1'b0, rd_addr} >= DEPTH_L);
  assign bank_re    = strm_issue | (rd_fire & ~rd_oob);
  assign bank_raddr = strm_issue ? issue_idx[ADDR_WIDTH-1:0] : rd_addr;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_bank
    localparam int unsigned LO = ch_lo(k, DATA_WIDTH);
    logic [DATA_WIDTH-1:0] wslice;
    logic [BW-1:0]         wword, rword;
    assign wslice = in_data[LO +: DATA_WIDTH];
`ifdef VEC_MEM_PARITY_EN
    assign wword           = {^wslice, wslice};
    assign bank_perr_ch[k] = ^rword;
`else
    assign wword           = wslice;
    assign bank_perr_ch[k] = 1'b0;
`endif
    assign bank_flat[LO +: DATA_WIDTH] = rword[DATA_WIDTH-1:0];

    vec_mem_bank #(
      .WIDTH     (BW),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk  (clk),
      .we   (wr_fire),
      .waddr(wr_ptr),
      .wdata(wword),
      .re   (bank_re),
      .raddr(bank_raddr),
      .rdata(rword)
    );
  end

  assign bank_perr = |bank_perr_ch;

  always_comb begin
    sk_data_nxt = sk_data;
    sk_last_nxt = sk_last;
    sk_perr_nxt = sk_perr;
    count_nxt   = count;
    if (pop) begin
      sk_data_nxt[0] = sk_data[1];
      sk_last_nxt[0] = sk_last[1];
      sk_perr_nxt[0] = sk_perr[1];
      count_nxt      = count - 2'd1;
    end else begin
      // A held head reports its parity error only on its first valid cycle.
      sk_perr_nxt[0] = 1'b0;
    end
    if (inflight) begin
      sk_data_nxt[count_nxt[0]] = bank_flat;
      sk_last_nxt[count_nxt[0]] = inflight_last;
      sk_perr_nxt[count_nxt[0]] = bank_perr;
      count_nxt                 = count_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_oob_q      <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      count         <= '0;
      sk_data       <= '0;
      sk_last       <= '0;
      sk_perr       <= '0;
    end else begin
      done_q     <= wr_last;
      err_q      <= proto_err;
      rd_valid_q <= rd_fire;
      rd_oob_q   <= rd_fire & rd_oob;
      if (load_go) begin
        len    <= (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
        wr_ptr <= '0;
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (strm_issue) rd_ptr <= issue_idx + LW'(1);
      inflight      <= strm_issue;
      inflight_last <= strm_issue && (issue_idx == len - LW'(1));
      count         <= count_nxt;
      sk_data       <= sk_data_nxt;
      sk_last       <= sk_last_nxt;
      sk_perr       <= sk_perr_nxt;
    end
  end

  assign in_ready   = (state == LOAD);
  assign busy       = (state == LOAD) || (state == STREAM);
  assign done       = done_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = (rd_valid_q && !rd_oob_q) ? bank_flat : '0;
  assign strm_valid = (count != 2'd0);
  assign strm_data  = strm_valid ? sk_data[0] : '0;
  assign strm_last  = strm_valid & sk_last[0];
  assign err        = err_q | (rd_valid_q & (rd_oob_q | bank_perr)) | (strm_valid & sk_perr[0]);

endmodule

// File: tb/tb_vec_mem_controller.sv
// Randomized self-checking bench for vec_mem_controller against an array reference model.
module tb_vec_mem_controller;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   cfg_len;
  logic          start, in_valid, in_ready, busy, done;
  logic [15:0]   in_data, rd_data, strm_data;
  logic          rd_en, rd_valid, strm_start, strm_valid, strm_ready, strm_last, err;
  logic [AW-1:0] rd_addr;

  logic [15:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  logic [15:0] wvec [DEPTH];
  int          ref_len;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vec_mem_controller #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NC),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .strm_start(strm_start),
    .strm_valid(strm_valid),
    .strm_ready(strm_ready),
    .strm_data (strm_data),
    .strm_last (strm_last),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_strm_valid", strm_valid, 0);
    check("rst_strm_last", strm_last, 0);
    check("rst_strm_data", strm_data, 0);
    check("rst_err", err, 0);
  endtask

  task automatic rd_check(input int a);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
    check("rd_valid", rd_valid, 1);
    check("rd_data", rd_data, ref_mem[a]);
    check("rd_err", err, 0);
    tick();
    check("rd_valid_pulse", rd_valid, 0);
  endtask

  task automatic do_load(input int cfg, input int gap_pct, input int gap_at,
                         input bit poke, input bit fixed, input bit rdw);
    int L;
    logic [15:0] d, old;
    bit chk_old;
    L = (cfg > DEPTH) ? DEPTH : cfg;
    start = 1'b1;
    cfg_len = (AW + 1)'(cfg);
    tick();
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 1);
    check("load_err", err, 0);
    if (poke) begin
      strm_start = 1'b1;
      tick();
      strm_start = 1'b0;
      check("load_strm_err", err, 1);
      check("load_stays", in_ready, 1);
      tick();
      check("load_err_pulse", err, 0);
    end
    for (int i = 0; i < L; i++) begin
      if (i == gap_at || $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        tick();
        check("load_gap_done", done, 0);
      end
      d = fixed ? wvec[i] : 16'($urandom);
      chk_old = rdw && known[i];
      old = ref_mem[i];
      in_valid = 1'b1;
      in_data = d;
      start = 1'($urandom_range(1));
      cfg_len = 1;
      rd_en = rdw;
      rd_addr = AW'(i);
      tick();
      ref_mem[i] = d;
      known[i] = 1'b1;
      in_valid = 1'b0;
      start = 1'b0;
      rd_en = 1'b0;
      check("load_done", done, (i == L - 1));
      check("load_err_w", err, 0);
      if (rdw) check("load_rd_valid", rd_valid, 1);
      if (chk_old) check("load_read_first", rd_data, old);
    end
    check("load_end_busy", busy, 0);
    check("load_end_in_ready", in_ready, 0);
    tick();
    check("load_done_pulse", done, 0);
    ref_len = L;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 per valid beat, else random.
  task automatic run_stream(input int mode, input int abort_at);
    int idx, cyc, first, vcnt;
    bit stalled;
    logic [15:0] held_d;
    logic held_l;
    idx = 0; cyc = 1; first = -1; vcnt = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    rd_en = 1'b0;
    strm_ready = 1'b0;
    strm_start = 1'b1;
    tick();
    strm_start = 1'b0;
    while (idx < ref_len && cyc < 400) begin
      if (abort_at != 0 && idx == abort_at) break;
      if (stalled) begin
        check("hold_valid", strm_valid, 1);
        check("hold_data", strm_data, held_d);
        check("hold_last", strm_last, held_l);
      end
      if (strm_valid) begin
        if (first < 0) begin
          first = cyc;
          check("strm_latency", cyc, 2);
        end
        check("strm_data", strm_data, ref_mem[idx]);
        check("strm_last", strm_last, (idx == ref_len - 1));
      end else begin
        check("strm_last_idle", strm_last, 0);
      end
      check("strm_busy", busy, 1);
      check("strm_rd_valid", rd_valid, 0);
      check("strm_err", err, 0);
      case (mode)
        0:       strm_ready = 1'b1;
        1:       strm_ready = (vcnt % 3 == 0);
        default: strm_ready = 1'($urandom_range(1));
      endcase
      if (strm_valid) vcnt++;
      stalled = strm_valid && !strm_ready;
      held_d = strm_data;
      held_l = strm_last;
      if (strm_valid && strm_ready) idx++;
      rd_en = 1'($urandom_range(1));
      rd_addr = AW'($urandom);
      strm_start = 1'($urandom_range(1));
      start = 1'($urandom_range(1));
      cfg_len = 1;
      tick();
      cyc++;
    end
    strm_start = 1'b0;
    start = 1'b0;
    rd_en = 1'b0;
    strm_ready = 1'b0;
    if (abort_at == 0) begin
      check("strm_count", idx, ref_len);
      if (mode == 0) check("strm_cycles", cyc, ref_len + 2);
      check("strm_end_busy", busy, 0);
      check("strm_end_valid", strm_valid, 0);
      check("strm_end_err", err, 0);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_len = '0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_en = 1'b0; rd_addr = '0; strm_start = 1'b0; strm_ready = 1'b0;
    ref_len = 0;
    for (int i = 0; i < DEPTH; i++) begin
      known[i] = 1'b0;
      ref_mem[i] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs();

    // zero length start is rejected
    start = 1'b1;
    cfg_len = '0;
    tick();
    start = 1'b0;
    check("len0_err", err, 1);
    check("len0_idle", busy, 0);
    tick();
    check("len0_err_pulse", err, 0);
    check("len0_still_idle", in_ready, 0);

    // three element load with an idle gap
    wvec[0] = {8'd200, 8'd10};
    wvec[1] = {8'd150, 8'd20};
    wvec[2] = {8'd100, 8'd30};
    do_load(3, 0, 1, 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < 3; a++) rd_check(a);

    // full-depth load, stream, then replay with random backpressure
    for (int i = 0; i < DEPTH; i++) wvec[i] = {~8'(i), 8'(i)};
    do_load(32, 10, -1, 1'b0, 1'b1, 1'b1);
    run_stream(0, 0);
    run_stream(2, 0);
    rd_check(0);
    rd_check(31);

    // short stream with stall pattern
    do_load(4, 0, -1, 1'b0, 1'b0, 1'b1);
    run_stream(1, 0);

    // length clamp plus stream request during load
    do_load(40, 30, -1, 1'b1, 1'b0, 1'b1);
    check("clamp_len", ref_len, 32);
    run_stream(2, 0);

    // single element boundary
    do_load(1, 0, -1, 1'b0, 1'b0, 1'b1);
    run_stream(0, 0);
    run_stream(1, 0);

    // reset in the middle of a stream
    do_load(4, 0, -1, 1'b0, 1'b0, 1'b0);
    run_stream(0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs();
    do_load(4, 0, -1, 1'b0, 1'b0, 1'b1);
    run_stream(0, 0);

    for (int it = 0; it < 6; it++) begin
      do_load(int'($urandom_range(40, 1)), 20, -1, 1'b0, 1'b0, 1'b1);
      for (int r = 0; r < 3; r++) rd_check(int'($urandom_range(ref_len - 1)));
      run_stream(int'($urandom_range(2)), 0);
    end

`ifdef VEC_MEM_PARITY_EN
    do_load(8, 0, -1, 1'b0, 1'b0, 1'b0);
    u_dut.g_bank[0].u_bank.mem[5] = u_dut.g_bank[0].u_bank.mem[5] ^ 9'h001;
    rd_en = 1'b1;
    rd_addr = 5;
    tick();
    rd_en = 1'b0;
    check("par_valid", rd_valid, 1);
    check("par_err", err, 1);
    check("par_data", rd_data, ref_mem[5] ^ 16'h0001);
    tick();
    rd_check(4);
    rd_check(6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
